// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low keypad, synchronises and debounces the rows,
// and encodes accepted presses into calculator command strobes. Define KEYPAD_AUTOREPEAT_EN for digit auto-repeat.
module keypad_encoder #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] data_out,
  output logic [3:0] op,
  output logic       digit_in,
  output logic       op_in,
  output logic       execute_in,
  output logic       clear_req
);

  // state       | meaning
  // ST_SCAN     | column advances each period, looking for a single low row
  // ST_DEBOUNCE | column frozen, counting consecutive matching samples
  // ST_EMIT     | one cycle, the registered strobe for the key is high
  // ST_HOLD     | column frozen, waiting for DEBOUNCE all-high samples
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB_N     = 4'(DEBOUNCE);

  state_t        state_q, state_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    key_row_q, key_row_d;
  logic [1:0]    key_col_q, key_col_d;
  logic [3:0]    data_q, data_d;
  logic [3:0]    op_q, op_d;
  logic          digit_q, digit_d;
  logic          op_in_q, op_in_d;
  logic          exec_q, exec_d;
  logic          clr_q, clr_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [5:0]    hold_cnt_q, hold_cnt_d;
`endif

  logic       sample;
  logic [3:0] rows_low;
  logic       single_low;
  logic [1:0] low_idx;
  logic       same_key;
  logic       emit_go;

  logic       key_is_digit;
  logic       key_is_op;
  logic       key_is_exec;
  logic       key_is_clr;
  logic [3:0] key_val;
  logic [3:0] key_op;

  assign sample     = (div_q == DIV_LAST);
  assign rows_low   = ~row_s2_q;
  assign single_low = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
  assign same_key   = single_low && (low_idx == key_row_q);
  assign div_d      = sample ? '0 : div_q + 1'b1;

  always_comb begin
    low_idx = 2'd0;
    case (rows_low)
      4'b0001: low_idx = 2'd0;
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  // Decode works on the next-state key so DEBOUNCE=1 can emit straight from ST_SCAN.
  always_comb begin
    key_is_digit = 1'b0;
    key_is_op    = 1'b0;
    key_is_exec  = 1'b0;
    key_is_clr   = 1'b0;
    key_val      = 4'd0;
    key_op       = 4'd0;
    if (key_col_d == 2'd3) begin
      case (key_row_d)
        2'd0: begin key_is_op = 1'b1; key_op = 4'b0100; end
        2'd1: begin key_is_op = 1'b1; key_op = 4'b0010; end
        2'd2: begin key_is_op = 1'b1; key_op = 4'b0001; end
        default: ;
      endcase
    end else if (key_row_d == 2'd3) begin
      case (key_col_d)
        2'd0:    key_is_clr = 1'b1;
        2'd1:    begin key_is_digit = 1'b1; key_val = 4'd0; end
        default: key_is_exec = 1'b1;
      endcase
    end else begin
      key_is_digit = 1'b1;
      key_val      = ({2'b00, key_row_d} * 4'd3) + {2'b00, key_col_d} + 4'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    emit_go   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    unique case (state_q)
      ST_SCAN: begin
        if (sample) begin
          if (single_low) begin
            key_row_d = low_idx;
            key_col_d = col_q;
            cnt_d     = 4'd1;
            if (DB_N == 4'd1) begin
              state_d = ST_EMIT;
              emit_go = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (same_key) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_N) begin
              state_d = ST_EMIT;
              emit_go = 1'b1;
            end
          end else begin
            cnt_d   = 4'd0;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_EMIT: begin
        cnt_d   = 4'd0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (sample) begin
          if (rows_low == 4'd0) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_cnt_d = 6'd0;
`endif
            if (cnt_q + 4'd1 == DB_N) begin
              cnt_d   = 4'd0;
              col_d   = col_q + 2'd1;
              state_d = ST_SCAN;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            // First repeat after 32 held samples; restarting at 24 gives every 8 after that.
            if (same_key && key_is_digit) begin
              if (hold_cnt_q == 6'd31) begin
                hold_cnt_d = 6'd24;
                state_d    = ST_EMIT;
                emit_go    = 1'b1;
              end else begin
                hold_cnt_d = hold_cnt_q + 6'd1;
              end
            end else begin
              hold_cnt_d = 6'd0;
            end
`endif
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
`ifdef KEYPAD_AUTOREPEAT_EN
    if ((state_q == ST_SCAN) || (state_q == ST_DEBOUNCE)) hold_cnt_d = 6'd0;
`endif
  end

  always_comb begin
    digit_d = emit_go && key_is_digit;
    op_in_d = emit_go && key_is_op;
    exec_d  = emit_go && key_is_exec;
    clr_d   = emit_go && key_is_clr;
    data_d  = digit_d ? key_val : data_q;
    op_d    = op_in_d ? key_op : op_q;
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SCAN;
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      div_q     <= '0;
      col_q     <= 2'd0;
      cnt_q     <= 4'd0;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
      data_q    <= 4'd0;
      op_q      <= 4'd0;
      digit_q   <= 1'b0;
      op_in_q   <= 1'b0;
      exec_q    <= 1'b0;
      clr_q     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_cnt_q <= 6'd0;
`endif
    end else begin
      state_q   <= state_d;
      row_s1_q  <= row_in;
      row_s2_q  <= row_s1_q;
      div_q     <= div_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      data_q    <= data_d;
      op_q      <= op_d;
      digit_q   <= digit_d;
      op_in_q   <= op_in_d;
      exec_q    <= exec_d;
      clr_q     <= clr_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign col_out    = ~(4'b0001 << col_q);
  assign data_out   = data_q;
  assign op         = op_q;
  assign digit_in   = digit_q;
  assign op_in      = op_in_q;
  assign execute_in = exec_q;
  assign clear_req  = clr_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder: vector table, hand-written timing/reset sequences and
// randomized presses checked against a keymap-level model of the keypad.
`timescale 1ns/1ps
module tb_keypad_encoder;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       Clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_in, col_out, data_out, op;
  logic       digit_in, op_in, execute_in, clear_req;

  logic        raw_mode = 1'b1;
  logic [3:0]  raw_rows = 4'hF;
  logic [15:0] key_down = '0;
  logic [3:0]  matrix_rows;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  string  keymap_s = "123A456B789C*0#D";

  typedef struct {
    int         kind;   // 0 digit, 1 op, 2 execute, 3 clear, -1 nothing
    logic [3:0] data;
    logic [3:0] opc;
    longint     t;
  } ev_t;

  typedef struct {
    int         key;
    int         kind;
    logic [3:0] data;
    logic [3:0] opc;
  } vec_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t mon_e;

  keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .Clock(Clock), .reset(reset), .row_in(row_in), .col_out(col_out),
    .data_out(data_out), .op(op), .digit_in(digit_in), .op_in(op_in),
    .execute_in(execute_in), .clear_req(clear_req)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Passive keypad: a held key pulls its row low whenever its column is driven.
  always_comb begin
    matrix_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col_out[c]) matrix_rows[r] = 1'b0;
  end
  assign row_in = raw_mode ? raw_rows : matrix_rows;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (reset) begin
      int n;
      n = int'(digit_in) + int'(op_in) + int'(execute_in) + int'(clear_req);
      chk("strobe_onehot", 32'(n > 1), 32'(0));
      if (n > 0) begin
        mon_e.kind = digit_in ? 0 : op_in ? 1 : execute_in ? 2 : 3;
        mon_e.data = data_out;
        mon_e.opc  = op;
        mon_e.t    = cyc;
        obs_q.push_back(mon_e);
      end
    end
  end

  task automatic push_exp(input int kind, input logic [3:0] d, input logic [3:0] o);
    ev_t e;
    if (kind < 0) return;
    e.kind = kind; e.data = d; e.opc = o; e.t = 0;
    exp_q.push_back(e);
  endtask

  // Reference: what a key means on the calculator, from the printed key legend.
  task automatic model_key(input int k, output int kind, output logic [3:0] d, output logic [3:0] o);
    byte ch;
    ch = keymap_s[k];
    kind = -1; d = 4'd0; o = 4'd0;
    if (ch >= "0" && ch <= "9") begin kind = 0; d = 4'(ch - "0"); end
    else if (ch == "A") begin kind = 1; o = 4'b0100; end
    else if (ch == "B") begin kind = 1; o = 4'b0010; end
    else if (ch == "C") begin kind = 1; o = 4'b0001; end
    else if (ch == "#") kind = 2;
    else if (ch == "*") kind = 3;
  endtask

  task automatic check_events(input string name);
    chk({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({name, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
      if (exp_q[i].kind == 0) chk({name, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
      if (exp_q[i].kind == 1) chk({name, "_op"}, 32'(obs_q[i].opc), 32'(exp_q[i].opc));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic press(input int k, input int hold, input int rel);
    @(negedge Clock); key_down[k] = 1'b1;
    repeat (hold) @(negedge Clock);
    key_down[k] = 1'b0;
    repeat (rel) @(negedge Clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   first, kind, hold_max;
    logic [3:0] d, o;
    logic saw_c3;

    vecs[0]  = '{0,  0, 4'd1, 4'd0};       // 1
    vecs[1]  = '{1,  0, 4'd2, 4'd0};       // 2
    vecs[2]  = '{3,  1, 4'd0, 4'b0100};    // A add
    vecs[3]  = '{2,  0, 4'd3, 4'd0};       // 3
    vecs[4]  = '{14, 2, 4'd0, 4'd0};       // #
    vecs[5]  = '{7,  1, 4'd0, 4'b0010};    // B subtract
    vecs[6]  = '{11, 1, 4'd0, 4'b0001};    // C multiply
    vecs[7]  = '{13, 0, 4'd0, 4'd0};       // 0
    vecs[8]  = '{10, 0, 4'd9, 4'd0};       // 9
    vecs[9]  = '{15, -1, 4'd0, 4'd0};      // D reserved
    vecs[10] = '{12, 3, 4'd0, 4'd0};       // *

    // Reset values with random row activity.
    for (int i = 0; i < 6; i++) begin
      raw_rows = 4'($urandom);
      @(negedge Clock);
      chk("rst_col", 32'(col_out), 32'(4'b1110));
      chk("rst_data", 32'(data_out), 32'(0));
      chk("rst_op", 32'(op), 32'(0));
      chk("rst_strobes", 32'({digit_in, op_in, execute_in, clear_req}), 32'(0));
    end

    // Latency: row1 held low from reset release, column 0 -> key 4.
    raw_rows = 4'b1101;
    @(negedge Clock); reset = 1'b1;
    first = -1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge Clock); #1;
      if (digit_in && first < 0) first = e;
      if (e == 12) chk("lat_data", 32'(data_out), 32'(4));
      if (e == 13) begin
        chk("lat_pulse_width", 32'(digit_in), 32'(0));
        raw_rows = 4'hF;
      end
      if (e == 23) chk("lat_col_frozen", 32'(col_out), 32'(4'b1110));
      if (e == 24) chk("lat_col_next", 32'(col_out), 32'(4'b1101));
    end
    chk("lat_edge", 32'(first), 32'(12));
    push_exp(0, 4'd4, 4'd0);
    check_events("latency");

    // Reset while debouncing key 9.
    @(negedge Clock); reset = 1'b0; raw_mode = 1'b0;
    repeat (3) @(negedge Clock);
    key_down[10] = 1'b1; reset = 1'b1;
    repeat (13) @(posedge Clock); #1;
    chk("midrst_col_frozen", 32'(col_out), 32'(4'b1011));
    repeat (4) @(posedge Clock); #1;
    reset = 1'b0;
    #1 chk("midrst_strobe", 32'(digit_in), 32'(0));
    key_down = '0;
    repeat (3) @(negedge Clock);
    reset = 1'b1;
    repeat (60) @(negedge Clock);
    chk("midrst_data", 32'(data_out), 32'(0));
    check_events("midrst");

    // Key 5 held for 100 cycles.
    press(5, 100, 60);
    push_exp(0, 4'd5, 4'd0);
    check_events("digit5");

    // Command sequence and key-map table.
    foreach (vecs[i]) begin
      press(vecs[i].key, 80, 50);
      push_exp(vecs[i].kind, vecs[i].data, vecs[i].opc);
    end
    check_events("vectors");
    chk("vec_data_held", 32'(data_out), 32'(9));
    chk("vec_op_held", 32'(op), 32'(4'b0001));

    // Bounce on key 7: each blip covers exactly one sample.
    for (int i = 0; i < 3; i++) press(8, 4, 40);
    check_events("bounce");
    press(8, 80, 50);
    push_exp(0, 4'd7, 4'd0);
    check_events("bounce_clean");

    // Ghost on column 0, then reserved D, then *.
    saw_c3 = 1'b0;
    @(negedge Clock); key_down[0] = 1'b1; key_down[4] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (col_out == 4'b0111) saw_c3 = 1'b1;
    end
    key_down = '0;
    repeat (50) @(negedge Clock);
    chk("ghost_scanning", 32'(saw_c3), 32'(1));
    check_events("ghost");
    press(15, 80, 50);
    check_events("reserved_d");
    press(12, 80, 50);
    push_exp(3, 4'd0, 4'd0);
    check_events("star");

    // Random single-key presses against the keymap model.
    hold_max = 100;
    for (int i = 0; i < 25; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      model_key(k, kind, d, o);
      push_exp(kind, d, o);
      press(k, int'($urandom_range(60, hold_max)), int'($urandom_range(40, 80)));
    end
    check_events("random");

`ifdef KEYPAD_AUTOREPEAT_EN
    // Key 4 held: strobes at emit, +32, +40, +48, +56 samples.
    @(negedge Clock); key_down[4] = 1'b1;
    first = 0;
    for (int i = 0; i < 100 && obs_q.size() == 0; i++) @(negedge Clock);
    chk("rep_first_seen", 32'(obs_q.size() > 0), 32'(1));
    repeat (240) @(negedge Clock);
    key_down = '0;
    repeat (60) @(negedge Clock);
    if (obs_q.size() == 5) begin
      chk("rep_gap1", 32'(obs_q[1].t - obs_q[0].t), 32'(32 * SCAN_DIV));
      chk("rep_gap2", 32'(obs_q[2].t - obs_q[0].t), 32'(40 * SCAN_DIV));
      chk("rep_gap3", 32'(obs_q[3].t - obs_q[0].t), 32'(48 * SCAN_DIV));
      chk("rep_gap4", 32'(obs_q[4].t - obs_q[0].t), 32'(56 * SCAN_DIV));
    end
    for (int i = 0; i < 5; i++) push_exp(0, 4'd4, 4'd0);
    check_events("repeat");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

- Scans a 4x4 matrix keypad, synchronises and debounces the row returns, and encodes each accepted press into the calculator's command inputs.
- Outputs are a 4-bit digit value, a one-hot op code, and single-cycle `digit_in` / `op_in` / `execute_in` / `clear_req` strobes.
- It is the producer end of the calculator control interface: its outputs connect directly to the calculator top level's `data_in`, `op`, `digit_in`, `op_in`, `execute_in` and `reset`.

## Interface

Parameters:
- `SCAN_DIV`, default 4: clock cycles each column is driven; legal range ≥ 3.
- `DEBOUNCE`, default 3: consecutive matching samples needed to accept a press or a release; legal range ≥ 1, ≤ 15.

Ports:
- `Clock`, input, 1: single clock; all state is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `row_in`, input, 4: keypad rows, active-low (externally pulled up); asynchronous to `Clock`.
- `col_out`, output, 4: column drive, active-low, exactly one bit low at all times.
- `data_out`, output, 4: digit value 0–9; valid while `digit_in` is high and held until the next digit.
- `op`, output, 4: one-hot op code (`0001` multiply, `0010` subtract, `0100` add); updated with `op_in` and held.
- `digit_in`, output, 1: 1-cycle pulse per accepted digit key.
- `op_in`, output, 1: 1-cycle pulse per accepted operator key.
- `execute_in`, output, 1: 1-cycle pulse per accepted `#`.
- `clear_req`, output, 1: 1-cycle pulse per accepted `*`.

## Operation

- **Key map** (row r, col c; r0 is the top row):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- **Key actions:**
  - A → add (`0100`); B → subtract (`0010`); C → multiply (`0001`).
  - D is reserved: it is debounced like any key but emits nothing.
- **Synchroniser:** `row_in` passes through a 2-flop synchroniser before any use.
- **Column counter:**
  - Counts 0..3 and wraps 3 → 0.
  - Each column is held for `SCAN_DIV` cycles.
  - Synchronised rows are sampled on the last cycle of each column period; this is the "sample".
- **FSM states:** `SCAN`, `DEBOUNCE`, `EMIT`, `HOLD`.
- **`SCAN`:**
  - Column advances every period.
  - At a sample with exactly one row low: latch {row, col}, freeze the column, set the match count to 1, go to `DEBOUNCE`.
  - Zero rows low, or ≥2 rows low (ghost or multi-key): stay in `SCAN`.
- **`DEBOUNCE`:**
  - Column stays frozen; evaluated at each sample.
  - Same single row low: count+1. When count = `DEBOUNCE`, go to `EMIT`.
  - Any other pattern: discard, resume `SCAN` with the next column.
  - With `DEBOUNCE` = 1, go from `SCAN` straight to `EMIT`.
- **`EMIT`:**
  - Lasts one cycle and asserts exactly one strobe.
  - Digit keys: `data_out` is updated in the same cycle as `digit_in`.
  - Operator keys: `op` is updated in the same cycle as `op_in`.
  - Then go to `HOLD`.
- **`HOLD`:**
  - Column stays frozen.
  - The release counter counts consecutive samples with all rows high; any low row resets it to 0.
  - When the counter reaches `DEBOUNCE`, go to `SCAN` with the next column.
  - Other keys pressed during `HOLD` are ignored.
- **Strobe rule:** at most one strobe is high in any cycle.
- **Reset:** reset asserted mid-operation aborts any pending press; no strobe is emitted for it.

## Timing

- **Reset values:**
  - `col_out` = `1110`; `data_out` = 0; `op` = `0000`.
  - All strobes = 0; FSM in `SCAN`; all counters 0.
- **Row-change latency:** a row change is visible to the sampler 2 cycles after it reaches `row_in`.
- **Press latency:** the strobe is high in the cycle after the `DEBOUNCE`-th matching sample. With defaults, the strobe rises 2×`SCAN_DIV`+1 = 9 cycles after the first accepting sample.
- **Repeat suppression:**
  - Without the repeat feature, a held key produces exactly one strobe.
  - The next press can be accepted no earlier than `DEBOUNCE` samples after the release.
- **Asynchronous release of reset:** the first column period begins on the first rising edge after release.

## Configuration

- **Macro:** `KEYPAD_AUTOREPEAT_EN`.
- **Defined:**
  - In `HOLD`, a digit key held continuously for 32 samples re-enters `EMIT` with the same `data_out`.
  - Subsequent repeats follow every 8 samples while the key stays held.
  - Operator, `#`, `*` and D keys never repeat.
  - The hold-sample counter is 6 bits.
- **Undefined:** one strobe per press; the repeat counter logic is absent.

## Test plan

All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3.

- **Reset:** hold `reset`=0 with random `row_in` → `col_out`=`1110`, all strobes 0, `data_out`=0, `op`=0.
- **Digit press:** press key 5 (r1, c1) held for 100 cycles → exactly one `digit_in` pulse with `data_out`=5; no other strobe.
- **Command sequence:** press 1, 2, A, 3, # in order with releases between → `digit_in`×3 (`data_out` 1, 2, 3), `op_in` once with `op`=`0100`, `execute_in` once.
- **Bounce rejection:** key 7 low for 1 sample then high, repeated 3 times → no strobe. A clean 3-sample press of 7 → `digit_in` with `data_out`=7.
- **Ghost and reserved keys:** r0 and r1 low together on c0 → no strobe, scanning continues. Press D → no strobe. Press `*` → one `clear_req`.
- **Reset mid-press:** assert `reset` while in `DEBOUNCE` on key 9 → no `digit_in`. With `KEYPAD_AUTOREPEAT_EN`, key 4 held for 60 samples → strobes at emit, +32, +40, +48, +56 samples.
